// File: rtl/hit_merge_pkg.sv
// Shared types and defaults for the R18 -> R19 hit merge queue.
// hit_t carries one sample-test hit: AXIS position words and COLORS color
// words, each SIGFIG bits wide and moved bit-exact (RADIX fraction bits are
// only a format note; no arithmetic is done on them here).
package hit_merge_pkg;

    localparam int SIGFIG             = 24;
    localparam int RADIX              = 10;
    localparam int AXIS               = 3;
    localparam int COLORS             = 3;
    localparam int FIFO_DEPTH_DEFAULT = 16;
    localparam int HALT_SLACK_DEFAULT = 8;

    typedef struct packed {
        logic [AXIS-1:0][SIGFIG-1:0]   pos;
        logic [COLORS-1:0][SIGFIG-1:0] color;
    } hit_t;

    // Slots available to this edge's pushes; a pop on the same edge frees one.
    function automatic int free_slots(input int depth, input int count, input logic pop);
        return depth - count + (pop ? 1 : 0);
    endfunction

endpackage

// File: rtl/hit_merge_queue_fifo.sv
// hit_fifo_2w1r: show-ahead FIFO of hit_t with two write ports and one read
// port. Port A is always written before port B on the same edge, and port B
// is only used together with port A. Storage is not reset; only pointers and
// count are. DEPTH must be a power of two so the pointers wrap naturally.
module hit_fifo_2w1r
    import hit_merge_pkg::*;
#(
    parameter int  DEPTH = FIFO_DEPTH_DEFAULT,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_a_en,
    input  hit_t          wr_a_data,
    input  logic          wr_b_en,
    input  hit_t          wr_b_data,
    input  logic          rd_en,
    output hit_t          head,
    output logic [CW-1:0] count,
    output logic [CW-1:0] count_next
);

    hit_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    assign head       = mem[rd_ptr];
    assign count_next = count + CW'(wr_a_en) + CW'(wr_b_en) - CW'(rd_en);

    // Storage write: port A at wr_ptr, port B in the following slot.
    always_ff @(posedge clk) begin
        if (wr_a_en) mem[wr_ptr] <= wr_a_data;
        if (wr_b_en) mem[wr_ptr + PW'(1)] <= wr_b_data;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(wr_a_en) + PW'(wr_b_en);
            rd_ptr <= rd_ptr + PW'(rd_en);
            count  <= count_next;
        end
    end

endmodule

// File: rtl/hit_merge_queue.sv
// hit_merge_queue: merges the two R18 sample-test hit lanes into one in-order
// R19 stream for the single-port z/framebuffer writer. Lane 0 always precedes
// lane 1 when both push on the same edge. When the FIFO cannot take every
// push, lane 1 is dropped before lane 0 and overflow_R19H latches until reset.
// halt_RnnH asks the rasterizer to stop while occupancy exceeds
// FIFO_DEPTH-HALT_SLACK, leaving room for hits already in flight.
// Optional: define HIT_MERGE_STATS_EN to add the hits_in/hits_out/drops
// counters (and a periodic simulation report).
module hit_merge_queue
    import hit_merge_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
    parameter int HALT_SLACK = HALT_SLACK_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [AXIS-1:0][SIGFIG-1:0]   hit_R18S,
    input  logic [COLORS-1:0][SIGFIG-1:0] color_R18U,
    input  logic                          hit_valid_R18H,
    input  logic [AXIS-1:0][SIGFIG-1:0]   hit_R18S2,
    input  logic [COLORS-1:0][SIGFIG-1:0] color_R18U2,
    input  logic                          hit_valid_R18H2,
    output logic [AXIS-1:0][SIGFIG-1:0]   hit_R19S,
    output logic [COLORS-1:0][SIGFIG-1:0] color_R19U,
    output logic                          hit_valid_R19H,
    input  logic                          hit_ready_R19H,
    output logic                          halt_RnnH,
    output logic                          overflow_R19H
`ifdef HIT_MERGE_STATS_EN
    ,
    output logic [31:0]                   hits_in_R19,
    output logic [31:0]                   hits_out_R19,
    output logic [31:0]                   drops_R19
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    hit_t          lane0;
    hit_t          lane1;
    hit_t          head;
    hit_t          wr_a_data;
    logic          wr_a_en;
    logic          wr_b_en;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          pop;
    logic          acc0;
    logic          acc1;
    logic          drop0;
    logic          drop1;
    int            space;

    assign lane0 = {hit_R18S, color_R18U};
    assign lane1 = {hit_R18S2, color_R18U2};

    // Head is valid whenever anything is queued; data is forced to zero when
    // empty so the outputs read as all-zero out of reset.
    assign hit_valid_R19H = (count != '0);
    assign hit_R19S       = hit_valid_R19H ? head.pos   : '0;
    assign color_R19U     = hit_valid_R19H ? head.color : '0;

    // Drop policy and lane compaction: accept lane 0 first, then lane 1, as
    // far as free space allows; a lone lane-1 hit uses write port A.
    always_comb begin
        pop       = hit_valid_R19H & hit_ready_R19H;
        space     = free_slots(FIFO_DEPTH, int'(count), pop);
        acc0      = hit_valid_R18H && (space >= 1);
        acc1      = hit_valid_R18H2 && (space >= (acc0 ? 2 : 1));
        drop0     = hit_valid_R18H & ~acc0;
        drop1     = hit_valid_R18H2 & ~acc1;
        wr_a_en   = acc0 | acc1;
        wr_b_en   = acc0 & acc1;
        wr_a_data = acc0 ? lane0 : lane1;
    end

    hit_fifo_2w1r #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr_a_en    (wr_a_en),
        .wr_a_data  (wr_a_data),
        .wr_b_en    (wr_b_en),
        .wr_b_data  (lane1),
        .rd_en      (pop),
        .head       (head),
        .count      (count),
        .count_next (count_next)
    );

    // Registered halt from next occupancy, and sticky overflow on any drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halt_RnnH     <= 1'b0;
            overflow_R19H <= 1'b0;
        end else begin
            halt_RnnH <= (count_next > CW'(FIFO_DEPTH - HALT_SLACK));
            if (drop0 | drop1) overflow_R19H <= 1'b1;
        end
    end

`ifdef HIT_MERGE_STATS_EN
    // Traffic counters: offered pushes, pops and drops, each wrapping at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hits_in_R19  <= '0;
            hits_out_R19 <= '0;
            drops_R19    <= '0;
        end else begin
            hits_in_R19  <= hits_in_R19 + 32'(hit_valid_R18H) + 32'(hit_valid_R18H2);
            hits_out_R19 <= hits_out_R19 + 32'(pop);
            drops_R19    <= drops_R19 + 32'(drop0) + 32'(drop1);
        end
    end

`ifndef SYNTHESIS
    // Simulation-only progress report every 100000 pops.
    always_ff @(posedge clk) begin
        if (!rst && pop && (((hits_out_R19 + 32'd1) % 32'd100000) == 32'd0))
            $display("hit_merge_queue stats: in=%0d out=%0d drops=%0d",
                     hits_in_R19, hits_out_R19 + 32'd1, drops_R19);
    end
`endif
`endif

endmodule

// File: tb/tb_hit_merge_queue.sv
// Testbench for hit_merge_queue. A queue-based reference model applies the
// push/pop/drop rules once per clock edge; each scenario task compares the
// DUT outputs against it on the falling edge.
`timescale 1ns/1ps
module tb_hit_merge_queue;
    import hit_merge_pkg::*;

    localparam int DEPTH = 16;
    localparam int SLACK = 8;

    logic                          clk = 1'b0;
    logic                          rst;
    logic [AXIS-1:0][SIGFIG-1:0]   hit_R18S, hit_R18S2, hit_R19S;
    logic [COLORS-1:0][SIGFIG-1:0] color_R18U, color_R18U2, color_R19U;
    logic                          hit_valid_R18H, hit_valid_R18H2;
    logic                          hit_valid_R19H, hit_ready_R19H;
    logic                          halt_RnnH, overflow_R19H;

    hit_t d0, d1, dut_head;

    assign hit_R18S    = d0.pos;
    assign color_R18U  = d0.color;
    assign hit_R18S2   = d1.pos;
    assign color_R18U2 = d1.color;
    assign dut_head    = {hit_R19S, color_R19U};

    hit_merge_queue dut (
        .clk             (clk),
        .rst             (rst),
        .hit_R18S        (hit_R18S),
        .color_R18U      (color_R18U),
        .hit_valid_R18H  (hit_valid_R18H),
        .hit_R18S2       (hit_R18S2),
        .color_R18U2     (color_R18U2),
        .hit_valid_R18H2 (hit_valid_R18H2),
        .hit_R19S        (hit_R19S),
        .color_R19U      (color_R19U),
        .hit_valid_R19H  (hit_valid_R19H),
        .hit_ready_R19H  (hit_ready_R19H),
        .halt_RnnH       (halt_RnnH),
        .overflow_R19H   (overflow_R19H)
    );

    always #5 clk = ~clk;

    // Reference model state
    hit_t exp_q[$];
    logic m_halt;
    logic m_over;
    int   checks;
    int   passes;

    function automatic hit_t rand_hit();
        hit_t h;
        for (int a = 0; a < AXIS; a++) h.pos[a] = SIGFIG'($urandom);
        for (int c = 0; c < COLORS; c++) h.color[c] = SIGFIG'($urandom);
        return h;
    endfunction

    function automatic logic m_valid();
        return exp_q.size() != 0;
    endfunction

    function automatic hit_t m_head();
        hit_t h;
        h = '0;
        if (exp_q.size() != 0) h = exp_q[0];
        return h;
    endfunction

    // One clock edge of the reference behaviour: pop, then pushes in lane
    // order while space lasts; anything that does not fit is dropped.
    task automatic model_edge();
        logic pop;
        int   space;
        int   n;
        if (rst) begin
            exp_q.delete();
            m_halt = 1'b0;
            m_over = 1'b0;
            return;
        end
        pop   = (exp_q.size() != 0) && hit_ready_R19H;
        space = DEPTH - exp_q.size() + (pop ? 1 : 0);
        if (pop) exp_q.delete(0);
        n = 0;
        if (hit_valid_R18H) begin
            if (n < space) begin exp_q.push_back(d0); n++; end
            else m_over = 1'b1;
        end
        if (hit_valid_R18H2) begin
            if (n < space) begin exp_q.push_back(d1); n++; end
            else m_over = 1'b1;
        end
        m_halt = exp_q.size() > (DEPTH - SLACK);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive(input logic p0, input logic p1, input logic rdy);
        d0 = rand_hit();
        d1 = rand_hit();
        hit_valid_R18H  = p0;
        hit_valid_R18H2 = p1;
        hit_ready_R19H  = rdy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        tick();
        tick();
        checks++;
        if (hit_valid_R19H !== 1'b0 || halt_RnnH !== 1'b0 || overflow_R19H !== 1'b0 ||
            hit_R19S !== '0 || color_R19U !== '0)
            $display("FAIL reset: valid=%b halt=%b ovf=%b head=%h, required all zero",
                     hit_valid_R19H, halt_RnnH, overflow_R19H, dut_head);
        else passes++;
        rst = 1'b0;
    endtask

    task automatic test_lane0_only();
        hit_t pushed;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b1);
            pushed = d0;
            tick();
            checks++;
            if (hit_valid_R19H !== 1'b1 || dut_head !== pushed || overflow_R19H !== 1'b0)
                $display("FAIL lane0_only[%0d]: valid=%b ovf=%b head=%h, required valid=1 ovf=0 head=%h",
                         i, hit_valid_R19H, overflow_R19H, dut_head, pushed);
            else passes++;
        end
        drive(1'b0, 1'b0, 1'b1);
        tick();
        checks++;
        if (hit_valid_R19H !== m_valid() || halt_RnnH !== m_halt || overflow_R19H !== m_over)
            $display("FAIL lane0_drain: valid=%b halt=%b ovf=%b, required valid=%b halt=%b ovf=%b",
                     hit_valid_R19H, halt_RnnH, overflow_R19H, m_valid(), m_halt, m_over);
        else passes++;
    endtask

    task automatic test_both_lanes();
        for (int i = 0; i < 14; i++) begin
            drive(i < 4, i < 4, 1'b1);
            tick();
            checks++;
            if (hit_valid_R19H !== m_valid() || (m_valid() && dut_head !== m_head()) ||
                halt_RnnH !== m_halt || overflow_R19H !== m_over)
                $display("FAIL both_lanes[%0d]: valid=%b halt=%b ovf=%b head=%h, required valid=%b halt=%b ovf=%b head=%h",
                         i, hit_valid_R19H, halt_RnnH, overflow_R19H, dut_head,
                         m_valid(), m_halt, m_over, m_head());
            else passes++;
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 12; i++) begin
            if (i == 6) drive(1'b1, 1'b0, 1'b0);
            else        drive(i < 10, i < 10, 1'b0);
            tick();
            checks++;
            if (hit_valid_R19H !== m_valid() || (m_valid() && dut_head !== m_head()) ||
                halt_RnnH !== m_halt || overflow_R19H !== m_over)
                $display("FAIL overflow[%0d]: valid=%b halt=%b ovf=%b head=%h, required valid=%b halt=%b ovf=%b head=%h",
                         i, hit_valid_R19H, halt_RnnH, overflow_R19H, dut_head,
                         m_valid(), m_halt, m_over, m_head());
            else passes++;
        end
        checks++;
        if (overflow_R19H !== 1'b1 || halt_RnnH !== 1'b1)
            $display("FAIL overflow_sticky: ovf=%b halt=%b, required ovf=1 halt=1",
                     overflow_R19H, halt_RnnH);
        else passes++;
    endtask

    task automatic test_mid_reset();
        hit_t pushed;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, 1'b1);
            tick();
            checks++;
            if (hit_valid_R19H !== m_valid() || (m_valid() && dut_head !== m_head()) ||
                halt_RnnH !== m_halt || overflow_R19H !== m_over)
                $display("FAIL pre_reset_drain[%0d]: valid=%b halt=%b ovf=%b head=%h, required valid=%b halt=%b ovf=%b head=%h",
                         i, hit_valid_R19H, halt_RnnH, overflow_R19H, dut_head,
                         m_valid(), m_halt, m_over, m_head());
            else passes++;
        end
        drive(1'b1, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        exp_q.delete();
        m_halt = 1'b0;
        m_over = 1'b0;
        #1;
        checks++;
        if (hit_valid_R19H !== 1'b0 || halt_RnnH !== 1'b0 || overflow_R19H !== 1'b0)
            $display("FAIL mid_reset_async: valid=%b halt=%b ovf=%b, required all zero",
                     hit_valid_R19H, halt_RnnH, overflow_R19H);
        else passes++;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0);
        pushed = d0;
        tick();
        checks++;
        if (hit_valid_R19H !== 1'b1 || dut_head !== pushed || halt_RnnH !== 1'b0)
            $display("FAIL post_reset_push: valid=%b halt=%b head=%h, required valid=1 halt=0 head=%h",
                     hit_valid_R19H, halt_RnnH, dut_head, pushed);
        else passes++;
    endtask

    task automatic test_full_push();
        for (int i = 0; i < 31; i++) begin
            if (i < 7)       drive(1'b1, 1'b1, 1'b0);
            else if (i == 7) drive(1'b1, 1'b0, 1'b0);
            else if (i < 13) drive(1'b1, 1'b0, 1'b1);
            else             drive(1'b0, 1'b0, 1'b1);
            tick();
            checks++;
            if (hit_valid_R19H !== m_valid() || (m_valid() && dut_head !== m_head()) ||
                halt_RnnH !== m_halt || overflow_R19H !== m_over)
                $display("FAIL full_push[%0d]: valid=%b halt=%b ovf=%b head=%h, required valid=%b halt=%b ovf=%b head=%h",
                         i, hit_valid_R19H, halt_RnnH, overflow_R19H, dut_head,
                         m_valid(), m_halt, m_over, m_head());
            else passes++;
            if (i == 12) begin
                checks++;
                if (overflow_R19H !== 1'b0 || halt_RnnH !== 1'b1 || exp_q.size() != DEPTH)
                    $display("FAIL full_push_no_drop: ovf=%b halt=%b, required ovf=0 halt=1 (model size %0d)",
                             overflow_R19H, halt_RnnH, exp_q.size());
                else passes++;
            end
        end
    endtask

    task automatic test_random();
        logic prev_hold;
        hit_t prev_head;
        prev_hold = 1'b0;
        prev_head = '0;
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 2) != 0);
            if (i % 97 == 96) hit_ready_R19H = 1'b1;
            prev_hold = hit_valid_R19H & ~hit_ready_R19H;
            prev_head = dut_head;
            tick();
            checks++;
            if (hit_valid_R19H !== m_valid() || (m_valid() && dut_head !== m_head()) ||
                halt_RnnH !== m_halt || overflow_R19H !== m_over ||
                (prev_hold && dut_head !== prev_head))
                $display("FAIL random[%0d]: valid=%b halt=%b ovf=%b head=%h, required valid=%b halt=%b ovf=%b head=%h hold=%b",
                         i, hit_valid_R19H, halt_RnnH, overflow_R19H, dut_head,
                         m_valid(), m_halt, m_over, m_head(), prev_hold);
            else passes++;
        end
    endtask

    initial begin
        checks = 0;
        passes = 0;
        m_halt = 1'b0;
        m_over = 1'b0;
        test_reset();
        test_lane0_only();
        test_both_lanes();
        test_overflow();
        test_mid_reset();
        test_full_push();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
